// File: rtl/core1_op_scheduler.sv
// core1_op_scheduler: round-robin time-sharing of the Core1 GF(2^m) datapath between two requesters.
// Optional perf counters are enabled with CORE1_SCHED_PERF_EN.
module core1_op_scheduler #(
  parameter int CORE_LAT = 2
`ifdef CORE1_SCHED_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [255:0] req0_a,
  input  logic [255:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [255:0] req1_a,
  input  logic [255:0] req1_b,
  output logic [2:0]   core_sel,
  output logic [255:0] core_a,
  output logic [255:0] core_b,
  input  logic [127:0] core_c,
  input  logic [127:0] core_d,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_c,
  output logic [127:0] rsp_d,
  output logic         rsp_err,
  output logic         busy
`ifdef CORE1_SCHED_PERF_EN
  , input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_cnt0,
  output logic [CNT_W-1:0] perf_cnt1
`endif
);
  localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [2:0] OP_MASK = 3'b100;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last, grant, acc, legal_in, cap;
  logic [2:0] op_q, op_in;
  logic [255:0] a_q, b_q;
  logic [CW-1:0] cnt;
  // grant=1 selects requester 1; on contention the one not served last wins
  assign grant = req1_valid && (!req0_valid || !last);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign acc = req0_ready || req1_ready;
  assign op_in = grant ? req1_op : req0_op;
  assign legal_in = op_in inside {3'b001, 3'b010, 3'b011, 3'b100};
  assign cap = (state == EXEC) && (cnt == '0);
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign core_sel = (state == EXEC) ? op_q : '0;
  assign core_a = (state == EXEC) ? a_q : '0;
  assign core_b = (state == EXEC) ? b_q : '0;
  always_comb begin
    state_nx = state;
    if (acc) state_nx = legal_in ? EXEC : RESP;
    else if (cap) state_nx = RESP;
    else if (rsp_valid && rsp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      rsp_id <= 1'b0;
      rsp_c <= '0;
      rsp_d <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        last <= grant;
        rsp_id <= grant;
        op_q <= op_in;
        a_q <= grant ? req1_a : req0_a;
        b_q <= grant ? req1_b : req0_b;
        cnt <= CW'(CORE_LAT - 1);
        rsp_err <= !legal_in;
        rsp_c <= '0;
        rsp_d <= '0;
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        // MASK results only carry the low 64 bits of D; everything else may float
        if (cap) begin
          rsp_c <= (op_q == OP_MASK) ? '0 : core_c;
          rsp_d <= (op_q == OP_MASK) ? {64'b0, core_d[63:0]} : core_d;
        end
      end
    end
  end
`ifdef CORE1_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else if (perf_clr) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else begin
      if (req0_ready && !(&perf_cnt0)) perf_cnt0 <= perf_cnt0 + 1'b1;
      if (req1_ready && !(&perf_cnt1)) perf_cnt1 <= perf_cnt1 + 1'b1;
    end
  end
`endif
endmodule
